// File: rtl/fir_pkg.sv
// Shared constants and loader state encoding for the distributed-arithmetic FIR core.
package fir_pkg;

  localparam int TAPS          = 64;
  localparam int BANKS         = 8;
  localparam int TAPS_PER_BANK = 8;
  localparam int LUT_W         = 20;
  localparam int CADDR_W       = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_e;

endpackage

// File: rtl/da_lut_sum.sv
// Combinational masked adder: sums the sign-extended coefficients whose mask bit is set.
module da_lut_sum
  import fir_pkg::*;
#(
  parameter int COEF_W = 16
) (
  input  logic [TAPS_PER_BANK-1:0][COEF_W-1:0] coefs,
  input  logic [TAPS_PER_BANK-1:0]             mask,
  output logic [LUT_W-1:0]                     sum
);

  function automatic logic [LUT_W-1:0] sext(input logic [COEF_W-1:0] c);
    return {{(LUT_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

  // Eight-term sum; COEF_W <= 17 keeps it exact in LUT_W bits.
  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS_PER_BANK; i++) begin
      if (mask[i]) begin
        sum = sum + sext(coefs[i]);
      end else begin
        sum = sum;
      end
    end
  end

endmodule

// File: rtl/da_coef_loader.sv
// Collects 64 coefficients and streams the 2048-entry DA partial-sum LUT image to the core.
// Optional DA_COEF_LOADER_SYMMETRIC_EN: linear-phase mode, 32 coefficients mirrored to 64 taps.
module da_coef_loader
  import fir_pkg::*;
#(
  parameter int COEF_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [COEF_W-1:0]  coef_in,
  input  logic               coef_valid,
  output logic               coef_ready,
  output logic [LUT_W-1:0]   CIN,
  output logic [CADDR_W-1:0] CADDR,
  output logic               CLOAD,
  output logic               load_busy,
  output logic               load_done
);

`ifdef DA_COEF_LOADER_SYMMETRIC_EN
  localparam logic [5:0] LAST_K = 6'd31;
`else
  localparam logic [5:0] LAST_K = 6'd63;
`endif

  loader_state_e state_r, state_s;
  logic [5:0]                           k_r;
  logic [CADDR_W-1:0]                   n_r;
  logic [TAPS-1:0][COEF_W-1:0]          coef_r;
  logic [TAPS_PER_BANK-1:0][COEF_W-1:0] bank_coefs_s;
  logic [LUT_W-1:0]                     sum_s;
  logic                                 accept_s;
  logic                                 start_ok_s;

  assign accept_s = (state_r == COLLECT) && coef_valid;

  // Next-state logic; start_ok_s marks an accepted load_start.
  always_comb begin
    state_s    = state_r;
    start_ok_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (load_start) begin
          state_s    = COLLECT;
          start_ok_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      COLLECT: begin
        if (accept_s && (k_r == LAST_K)) begin
          state_s = WRITE;
        end else begin
          state_s = COLLECT;
        end
      end
      WRITE: begin
        if (n_r == 11'h7FF) begin
          state_s = DONE;
        end else begin
          state_s = WRITE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Address bit i of bank b selects tap 8b+i.
  always_comb begin
    bank_coefs_s = '0;
    for (int i = 0; i < TAPS_PER_BANK; i++) begin
      bank_coefs_s[i] = coef_r[{n_r[10:8], i[2:0]}];
    end
  end

  da_lut_sum #(.COEF_W(COEF_W)) u_sum (
    .coefs (bank_coefs_s),
    .mask  (n_r[7:0]),
    .sum   (sum_s)
  );

  // State, counters, coefficient file and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      k_r        <= 6'd0;
      n_r        <= '0;
      coef_r     <= '0;
      coef_ready <= 1'b0;
      CIN        <= '0;
      CADDR      <= '0;
      CLOAD      <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state_r    <= state_s;
      coef_ready <= (state_s == COLLECT);
      load_busy  <= (state_s == COLLECT) || (state_s == WRITE) || (state_r == WRITE);

      if (start_ok_s) begin
        k_r <= 6'd0;
      end else if (accept_s) begin
        k_r <= k_r + 6'd1;
      end else begin
        k_r <= k_r;
      end

      if (accept_s) begin
        coef_r[k_r] <= coef_in;
`ifdef DA_COEF_LOADER_SYMMETRIC_EN
        coef_r[6'd63 - k_r] <= coef_in;
`endif
      end

      if (state_r == WRITE) begin
        n_r   <= n_r + 11'd1;
        CIN   <= sum_s;
        CADDR <= n_r;
      end else begin
        n_r <= '0;
      end
      CLOAD <= (state_r == WRITE);

      // A new accepted load clears done; only a completed final write sets it.
      if (start_ok_s) begin
        load_done <= 1'b0;
      end else if (CLOAD && (CADDR == 11'h7FF)) begin
        load_done <= 1'b1;
      end else begin
        load_done <= load_done;
      end
    end
  end

endmodule

// File: tb/tb_da_coef_loader.sv
// Scoreboard bench for da_coef_loader: stimulus queues expected LUT writes, a monitor checks them.
`timescale 1ns/1ps
module tb_da_coef_loader;

`ifdef DA_COEF_LOADER_SYMMETRIC_EN
  localparam int NCOEF = 32;
  localparam int LAT   = 2082;
`else
  localparam int NCOEF = 64;
  localparam int LAT   = 2114;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [15:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [19:0] CIN;
  logic [10:0] CADDR;
  logic        CLOAD;
  logic        load_busy;
  logic        load_done;

  always #5 clk = ~clk;

  da_coef_loader #(.COEF_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .CIN        (CIN),
    .CADDR      (CADDR),
    .CLOAD      (CLOAD),
    .load_busy  (load_busy),
    .load_done  (load_done)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [19:0] data;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      mon_e;
  logic [19:0] lut_seen[2048];
  logic [15:0] coef_vals[64];
  int          model[64];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accepts = 0;
  int          run_len = 0;
  bit          abort_pending = 1'b0;
  bit          prev_cload = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every CLOAD cycle is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (CLOAD === 1'b1) begin
      if (!prev_cload) check("accepts_before_first_cload", 40'(accepts), 40'(NCOEF));
      run_len++;
      lut_seen[CADDR] = CIN;
      if (exp_q.size() == 0) begin
        check("unexpected_cload", 40'(exp_q.size()), 40'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("caddr", 40'(CADDR), 40'(mon_e.addr));
        check("cin", 40'(CIN), 40'(mon_e.data));
      end
    end else if (prev_cload) begin
      if (abort_pending) abort_pending = 1'b0;
      else check("cload_run_len", 40'(run_len), 40'd2048);
      run_len = 0;
    end
    prev_cload = (CLOAD === 1'b1);
  end

  task automatic build_expected();
    int s;
    entry_t e;
    for (int k = 0; k < 64; k++) model[k] = 0;
    for (int k = 0; k < NCOEF; k++) begin
      model[k] = int'($signed(coef_vals[k]));
`ifdef DA_COEF_LOADER_SYMMETRIC_EN
      model[63-k] = int'($signed(coef_vals[k]));
`endif
    end
    for (int n = 0; n < 2048; n++) begin
      s = 0;
      for (int i = 0; i < 8; i++) if (n[i]) s += model[8*(n >> 8) + i];
      e.addr = n[10:0];
      e.data = s[19:0];
      exp_q.push_back(e);
      lut_seen[n] = 20'hxxxxx;
    end
  endtask

  task automatic begin_load(input bit toggle, output int c0);
    int  idx;
    int  guard;
    bit  acc;
    build_expected();
    accepts = 0;
    @(negedge clk);
    load_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    load_start = 1'b0;
    check("done_cleared_on_start", 40'(load_done), 40'd0);
    check("busy_after_start", 40'(load_busy), 40'd1);
    idx = 0;
    guard = 0;
    while (idx < NCOEF && guard < 400) begin
      coef_valid = !toggle || (guard[0] == 1'b0);
      coef_in = coef_vals[idx];
      acc = coef_valid && coef_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        accepts++;
      end
      guard++;
    end
    check("coefs_fed", 40'(idx), 40'(NCOEF));
    // Extra offered coefficients must not be accepted.
    coef_valid = 1'b1;
    coef_in = 16'hDEAD;
    for (int j = 0; j < 4; j++) begin
      acc = coef_valid && coef_ready;
      @(negedge clk);
      if (acc) accepts++;
    end
    coef_valid = 1'b0;
    check("accept_count", 40'(accepts), 40'(NCOEF));
  endtask

  task automatic wait_done(input bit check_lat, input int c0);
    int guard;
    guard = 0;
    while (load_done !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", 40'(load_done), 40'd1);
    if (check_lat) check("done_latency", 40'(cyc - c0), 40'(LAT));
    check("queue_drained", 40'(exp_q.size()), 40'd0);
  endtask

  task automatic wait_addr(input int a);
    int guard;
    guard = 0;
    while (!(CLOAD === 1'b1 && CADDR == a[10:0]) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_addr", 40'(CADDR), 40'(a));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1;
    load_start = 1'b0;
    coef_valid = 1'b0;
    coef_in = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: outputs stay zero, coef_valid ignored.
    for (int i = 0; i < 20; i++) begin
      coef_valid = 1'b1;
      coef_in = 16'($urandom);
      @(negedge clk);
      check("idle_outputs", 40'({coef_ready, CIN, CADDR, CLOAD, load_busy, load_done}), 40'd0);
    end
    coef_valid = 1'b0;

    // All +1: every entry is popcount of the address byte.
    for (int k = 0; k < 64; k++) coef_vals[k] = 16'd1;
    begin_load(1'b0, c0);
    wait_done(1'b1, c0);
    check("ones_0FF", 40'(lut_seen[11'h0FF]), 40'd8);
    check("ones_705", 40'(lut_seen[11'h705]), 40'd2);
    check("ones_000", 40'(lut_seen[11'h000]), 40'd0);
    check("hold_caddr", 40'(CADDR), 40'h7FF);
    check("hold_cin", 40'(CIN), 40'd8);
    check("idle_busy", 40'(load_busy), 40'd0);
    repeat (5) @(negedge clk);
    check("done_held", 40'(load_done), 40'd1);

    // Most negative coefficients.
    for (int k = 0; k < 64; k++) coef_vals[k] = 16'h8000;
    begin_load(1'b0, c0);
    wait_done(1'b0, c0);
    check("neg_3FF", 40'(lut_seen[11'h3FF]), 40'h0C0000);
    check("neg_301", 40'(lut_seen[11'h301]), 40'h0F8000);

    // coef[k]=k with gaps in coef_valid.
    for (int k = 0; k < 64; k++) coef_vals[k] = 16'(k);
    begin_load(1'b1, c0);
    wait_done(1'b0, c0);
`ifdef DA_COEF_LOADER_SYMMETRIC_EN
    check("ramp_701", 40'(lut_seen[11'h701]), 40'd7);
    check("ramp_7FF", 40'(lut_seen[11'h7FF]), 40'd28);
`else
    check("ramp_701", 40'(lut_seen[11'h701]), 40'd56);
    check("ramp_7FF", 40'(lut_seen[11'h7FF]), 40'd476);
`endif

    // load_start mid-WRITE is ignored; reset at n=1000 aborts.
    for (int k = 0; k < 64; k++) coef_vals[k] = 16'(3 * k - 50);
    begin_load(1'b0, c0);
    wait_addr(500);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    wait_addr(999);
    abort_pending = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cload", 40'(CLOAD), 40'd0);
    check("abort_done", 40'(load_done), 40'd0);
    check("abort_busy", 40'(load_busy), 40'd0);
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_quiet", 40'({CLOAD, load_done}), 40'd0);
    end
    begin_load(1'b0, c0);
    wait_done(1'b1, c0);

`ifdef DA_COEF_LOADER_SYMMETRIC_EN
    // Linear-phase: coef[k]=k+1 mirrored onto tap 63-k.
    for (int k = 0; k < 64; k++) coef_vals[k] = 16'(k + 1);
    begin_load(1'b0, c0);
    wait_done(1'b1, c0);
    check("sym_780", 40'(lut_seen[11'h780]), 40'd1);
    check("sym_001", 40'(lut_seen[11'h001]), 40'd1);
    check("sym_701", 40'(lut_seen[11'h701]), 40'd8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/da_coef_loader.md
# da_coef_loader

Coefficient-side writer for the distributed-arithmetic FIR core. It accepts a stream of 64 signed filter coefficients and computes the 2048 partial-sum LUT entries: 8 banks × 256 entries, each the sum of the coefficients selected by the address bits. It writes the entries through the core's CIN/CADDR/CLOAD load port, one entry per clock. It sits between the host/config path and the DA core, and signals completion so the core is started only after a full LUT image is resident.

## Interface
- COEF_W, 16, coefficient width, signed two's complement; legal range 2..17 so that an 8-term sum fits in 20 bits exactly
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle request to begin a new load
- coef_in  in  COEF_W  coefficient data, index order 0..63
- coef_valid  in  1  coef_in valid
- coef_ready  out  1  loader can accept a coefficient
- CIN  out  20  LUT write data
- CADDR  out  11  LUT write address: [10:8] bank, [7:0] entry
- CLOAD  out  1  write strobe; an entry is written on every clk edge where CLOAD=1
- load_busy  out  1  collecting or writing
- load_done  out  1  full LUT image written; held until the next accepted load_start or reset

## Operation
- States:
  - IDLE: coef_ready=0; load_start → COLLECT, coefficient index k=0.
  - COLLECT: coef_ready=1; each coef_valid&coef_ready stores coef[k] and increments k; the accept of coef[63] → WRITE with entry counter n=0.
  - WRITE: one entry per cycle, n = 0..2047; after the write with CADDR=2047 → DONE.
  - DONE: load_done=1; load_start → COLLECT, with load_done cleared the same edge.
- load_start is ignored in COLLECT and WRITE.
- Entry n, with bank b=n[10:8] and address a=n[7:0]: CIN = Σ_{i=0..7} a[i] ? sext20(coef[8b+i]) : 0. A bit i of the core's address maps to tap 8b+i.
- Arithmetic is exact with no saturation; sums are sign-extended to 20 bits. a=0 yields 0.
- coef_valid gaps are legal. coef_in is don't-care when coef_valid=0.

## Timing
- Reset values: coef_ready=0, CIN=0, CADDR=0, CLOAD=0, load_busy=0, load_done=0, state IDLE, coefficient registers 0.
- Reset mid-COLLECT or mid-WRITE aborts immediately. No further CLOAD is issued, and the partial LUT image is not flagged done.
- Summation is one registered stage: CIN, CADDR and CLOAD are all flops and change together.
- First CLOAD=1 is the cycle after the state becomes WRITE. CLOAD is then continuous for exactly 2048 cycles, with CADDR incrementing by 1 each cycle.
- load_done rises the cycle after the CADDR=2047 write.
- load_busy=1 from the cycle after load_start is accepted through the last CLOAD cycle inclusive.
- Minimum load, with coef_valid held high: 1 + 64 + 1 + 2048 cycles from load_start to load_done.
- CLOAD=0 outside WRITE. CIN and CADDR hold their last values when CLOAD=0.

## Configuration
- DA_COEF_LOADER_SYMMETRIC_EN defined: linear-phase mode.
  - COLLECT accepts only 32 coefficients, indices 0..31.
  - coef[63-k] = coef[k]; mirroring is applied when storing.
  - Transition to WRITE happens on the 32nd accept. Minimum load is 32 cycles shorter.
- Not defined: 64 independent coefficients, as described above.

## Structure
- Shared package fir_pkg:
  - TAPS=64, BANKS=8, TAPS_PER_BANK=8, LUT_W=20, CADDR_W=11
  - loader state enum (IDLE, COLLECT, WRITE, DONE)
- One natural sub-module, da_lut_sum: combinational 8-term masked signed adder (8 coefficients + 8-bit mask → 20-bit sum), instantiated once. The top owns the FSM, counters, coefficient register file and the output register stage.

## Test plan
- Reset held 3 cycles, then released with no load_start → all outputs 0 indefinitely; coef_valid is ignored.
- All coefficients +1, valid held high → exactly 2048 consecutive CLOAD cycles.
  - Every entry equals popcount(CADDR[7:0]), e.g. CADDR 0x0FF → CIN 8, CADDR 0x705 → 2.
  - load_done rises 2114 cycles after load_start.
- All coefficients 0x8000 (−32768) → CADDR 0x3FF writes CIN=20'hC0000, CADDR 0x301 writes 20'hF8000.
- coef[k]=k with coef_valid toggling every other cycle → CADDR 0x701 writes 56, 0x7FF writes 476. Exactly 64 accepts occur, with no CLOAD before the 64th.
- load_start pulsed mid-WRITE → ignored; reset asserted at n=1000 → CLOAD=0 the next cycle, load_done stays 0, and a fresh load then completes normally.
- With DA_COEF_LOADER_SYMMETRIC_EN: coef[k]=k+1 for k=0..31 → bank 7 entry 0x80 (tap 63) = 1, bank 0 entry 0x01 = 1. Exactly 32 accepts occur.
